// File: rtl/approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul_pipe
// Description : Three-stage valid/ready pipelined WIDTH x WIDTH unsigned
//               multiplier; each HALF x HALF quadrant product can be truncated
//               independently under a per-transaction mode field.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mul_pipe #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [3:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 out_exact
);

    localparam int               c_HALF      = WIDTH / 2;
    localparam logic [WIDTH-1:0] c_KEEP_MASK = {WIDTH{1'b1}} << TRUNC;

    if ((WIDTH < 4) || ((WIDTH % 2) != 0) || (TRUNC < 0) || (TRUNC >= WIDTH)) begin : g_param_check
        $error("approx_mul_pipe: WIDTH must be even and >= 4, and 0 <= TRUNC < WIDTH");
    end

    // Pipeline control: every stage advances together, bubbles are not squeezed.
    logic w_adv;
    logic w_accept;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;

    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_mode_q;

    logic [c_HALF-1:0] w_a_hi, w_a_lo, w_b_hi, w_b_lo;
    logic [WIDTH-1:0]  w_hh_raw, w_hl_raw, w_lh_raw, w_ll_raw;
    logic [WIDTH-1:0]  s2_hh_d, s2_hl_d, s2_lh_d, s2_ll_d;
    logic              s2_exact_d;

    logic [WIDTH-1:0]  s2_hh_q, s2_hl_q, s2_lh_q, s2_ll_q;
    logic              s2_exact_q;

    logic [2*WIDTH-1:0] w_mid;
    logic [2*WIDTH-1:0] s3_prod_d;
    logic [2*WIDTH-1:0] s3_prod_q;
    logic               s3_exact_q;

    function automatic logic [WIDTH-1:0] f_approx(
        input logic [WIDTH-1:0] p,
        input logic             en
    );
        return en ? (p & c_KEEP_MASK) : p;
    endfunction

    assign w_adv    = out_ready | ~s3_valid_q;
    assign w_accept = in_valid & w_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        if (w_adv) begin
            s1_valid_d = w_accept;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    // Stage 1: operands and mode are captured only on acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            s1_a_q    <= in_a;
            s1_b_q    <= in_b;
            s1_mode_q <= in_mode;
        end
    end

    assign w_a_hi = s1_a_q[WIDTH-1:c_HALF];
    assign w_a_lo = s1_a_q[c_HALF-1:0];
    assign w_b_hi = s1_b_q[WIDTH-1:c_HALF];
    assign w_b_lo = s1_b_q[c_HALF-1:0];

    assign w_hh_raw = {{c_HALF{1'b0}}, w_a_hi} * {{c_HALF{1'b0}}, w_b_hi};
    assign w_hl_raw = {{c_HALF{1'b0}}, w_a_hi} * {{c_HALF{1'b0}}, w_b_lo};
    assign w_lh_raw = {{c_HALF{1'b0}}, w_a_lo} * {{c_HALF{1'b0}}, w_b_hi};
    assign w_ll_raw = {{c_HALF{1'b0}}, w_a_lo} * {{c_HALF{1'b0}}, w_b_lo};

    always_comb begin
        s2_hh_d    = f_approx(w_hh_raw, s1_mode_q[3]);
        s2_hl_d    = f_approx(w_hl_raw, s1_mode_q[2]);
        s2_lh_d    = f_approx(w_lh_raw, s1_mode_q[1]);
        s2_ll_d    = f_approx(w_ll_raw, s1_mode_q[0]);
        s2_exact_d = (s1_mode_q == 4'b0000);
    end

    // Stage 2: quadrant products.
    always_ff @(posedge clk) begin
        if (w_adv && s1_valid_q) begin
            s2_hh_q    <= s2_hh_d;
            s2_hl_q    <= s2_hl_d;
            s2_lh_q    <= s2_lh_d;
            s2_ll_q    <= s2_ll_d;
            s2_exact_q <= s2_exact_d;
        end
    end

    // Middle terms are summed at full width so their carry is never lost.
    always_comb begin
        w_mid     = {{WIDTH{1'b0}}, s2_hl_q} + {{WIDTH{1'b0}}, s2_lh_q};
        s3_prod_d = {s2_hh_q, {WIDTH{1'b0}}} + (w_mid << c_HALF)
                  + {{WIDTH{1'b0}}, s2_ll_q};
    end

    // Stage 3 loads only real transactions, so bubbles never disturb the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_prod_q  <= '0;
            s3_exact_q <= 1'b0;
        end else if (w_adv && s2_valid_q) begin
            s3_prod_q  <= s3_prod_d;
            s3_exact_q <= s2_exact_q;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = s3_valid_q;
    assign out_prod  = s3_prod_q;
    assign out_exact = s3_exact_q;

endmodule
`default_nettype wire
